// File: rtl/monopix_pkg.sv
// Shared types and constants for the MONOPIX pixel matrix: readout word,
// configuration record and the reset/default values the top falls back to.
package monopix_pkg;

    localparam int MAX_NCOL  = 64;
    localparam int MAX_NROW  = 512;
    localparam int BCID_BITS = 6;
    localparam int DATA_BITS = 27;

    typedef struct packed {
        logic [5:0] col;
        logic [5:0] te;
        logic [5:0] le;
        logic [8:0] row;
    } t_data;

    // Sized for the largest matrix; columns/rows beyond NCOL/NROW are don't-care.
    typedef struct packed {
        logic                en_test_pattern;
        logic                en_readout;
        logic [MAX_NCOL-1:0] mask_col;
        logic [MAX_NROW-1:0] mask_row;
        logic [MAX_NCOL-1:0] col_pulse_sel;
        logic [MAX_NROW-1:0] inj_row;
    } t_conf;

    localparam t_conf CONF_DEFAULT = '{
        en_test_pattern: 1'b0,
        en_readout:      1'b1,
        mask_col:        '1,
        mask_row:        '1,
        col_pulse_sel:   '0,
        inj_row:         '0
    };

    localparam t_data TEST_PATTERN = t_data'(27'h5555555);

    function automatic logic [BCID_BITS-1:0] bin2gray(input logic [BCID_BITS-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/monopix_if.sv
// Pad-level configuration and readout signals between the chip and its
// external controller.
interface monopix_if;

    logic DEF_CONF_PAD;
    logic LD_CONF_PAD;
    logic SI_CONF_PAD;
    logic CONF_SHIFT_EN_PAD;
    logic SO_CONF_PAD;
    logic FREEZE_PAD;
    logic READ_PAD;
    logic TOKEN_PAD;
    logic OUT_PAD;

    modport master (
        output DEF_CONF_PAD, LD_CONF_PAD, SI_CONF_PAD, CONF_SHIFT_EN_PAD,
        output FREEZE_PAD, READ_PAD,
        input  SO_CONF_PAD, TOKEN_PAD, OUT_PAD
    );

    modport slave (
        input  DEF_CONF_PAD, LD_CONF_PAD, SI_CONF_PAD, CONF_SHIFT_EN_PAD,
        input  FREEZE_PAD, READ_PAD,
        output SO_CONF_PAD, TOKEN_PAD, OUT_PAD
    );

endinterface

// File: rtl/monopix_pixel.sv
// One pixel: registers its effective hit, timestamps leading/trailing edges
// with the gray-coded BCID and holds the result until the readout clears it.
module monopix_pixel
    import monopix_pkg::*;
(
    input  logic                 clk_bx,
    input  logic                 reset_n,
    input  logic                 hit,
    input  logic                 freeze,
    input  logic [BCID_BITS-1:0] gray,
    input  logic                 clear,
    output logic                 pending,
    output logic [BCID_BITS-1:0] le,
    output logic [BCID_BITS-1:0] te
);

    logic h;
    // Set only by a leading edge seen while live, so a pulse whose start was
    // frozen out cannot complete with a stale LE.
    logic armed;

    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            h       <= 1'b0;
            armed   <= 1'b0;
            pending <= 1'b0;
            le      <= '0;
            te      <= '0;
        end else begin
            h <= hit;
            if (clear) begin
                pending <= 1'b0;
            end else if (!freeze && !pending) begin
                if (hit && !h) begin
                    le    <= gray;
                    armed <= 1'b1;
                end else if (!hit && h && armed) begin
                    te      <= gray;
                    pending <= 1'b1;
                    armed   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/monopix.sv
// MONOPIX top: configuration shift/latch, BCID counter, pixel matrix,
// priority readout select and the 27-bit serializer.
module monopix
    import monopix_pkg::*;
#(
    parameter int NCOL = 4,
    parameter int NROW = 8
) (
    input  logic                 CLK_BX_PAD,
    input  logic                 RST_N_PAD,
    input  logic                 RESET_BCID_PAD,
    input  logic [NCOL*NROW-1:0] ANA_HIT,
    input  logic                 PULSE_PAD,
    output logic                 HIT_OR_PAD,
    monopix_if.slave             pads
);

    localparam int CONF_BITS = 2 + 2*NCOL + 2*NROW;
    localparam int NPIX      = NCOL * NROW;

    logic [CONF_BITS-1:0] conf_sr;
    t_conf                sr_conf;
    t_conf                conf_lat;
    t_conf                conf_eff;
    logic                 unused_conf;

    logic [BCID_BITS-1:0] bcid;
    logic [BCID_BITS-1:0] gray;

    logic [NPIX-1:0]      hit_eff;
    logic [NPIX-1:0]      pending;
    logic [NPIX-1:0]      sel_onehot;
    logic [NPIX-1:0]      pix_clear;
    logic [BCID_BITS-1:0] pix_le [NPIX];
    logic [BCID_BITS-1:0] pix_te [NPIX];

    logic                 sel_found;
    t_data                sel_word;
    logic                 read_q;
    logic                 read_edge;
    logic [DATA_BITS-1:0] ser;
    logic                 token_q;

    always_ff @(posedge CLK_BX_PAD or negedge RST_N_PAD) begin
        if (!RST_N_PAD) begin
            conf_sr <= '0;
        end else if (pads.CONF_SHIFT_EN_PAD) begin
            conf_sr <= {conf_sr[CONF_BITS-2:0], pads.SI_CONF_PAD};
        end
    end

    assign pads.SO_CONF_PAD = conf_sr[CONF_BITS-1];

    // Shift register layout, MSB first: tp, readout, mask_col, mask_row, pulse_sel, inj_row.
    always_comb begin
        sr_conf                 = '0;
        sr_conf.en_test_pattern = conf_sr[CONF_BITS-1];
        sr_conf.en_readout      = conf_sr[CONF_BITS-2];
        for (int c = 0; c < NCOL; c++) begin
            sr_conf.mask_col[c]      = conf_sr[2*NROW + NCOL + c];
            sr_conf.col_pulse_sel[c] = conf_sr[NROW + c];
        end
        for (int r = 0; r < NROW; r++) begin
            sr_conf.mask_row[r] = conf_sr[NROW + NCOL + r];
            sr_conf.inj_row[r]  = conf_sr[r];
        end
    end

    always_ff @(posedge CLK_BX_PAD or negedge RST_N_PAD) begin
        if (!RST_N_PAD) begin
            conf_lat <= CONF_DEFAULT;
        end else if (pads.LD_CONF_PAD) begin
            conf_lat <= sr_conf;
        end
    end

    assign conf_eff    = pads.DEF_CONF_PAD ? CONF_DEFAULT : conf_lat;
    assign unused_conf = ^conf_eff;

    always_ff @(posedge CLK_BX_PAD or negedge RST_N_PAD) begin
        if (!RST_N_PAD) begin
            bcid <= '0;
        end else if (RESET_BCID_PAD) begin
            bcid <= '0;
        end else begin
            bcid <= bcid + 1'b1;
        end
    end

    assign gray = bin2gray(bcid);

    always_comb begin
        hit_eff = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int r = 0; r < NROW; r++) begin
                hit_eff[c*NROW + r] = (ANA_HIT[c*NROW + r]
                                       | (PULSE_PAD & conf_eff.col_pulse_sel[c] & conf_eff.inj_row[r]))
                                      & conf_eff.mask_col[c] & conf_eff.mask_row[r];
            end
        end
    end

    for (genvar p = 0; p < NPIX; p++) begin : g_pix
        monopix_pixel u_pixel (
            .clk_bx  (CLK_BX_PAD),
            .reset_n (RST_N_PAD),
            .hit     (hit_eff[p]),
            .freeze  (pads.FREEZE_PAD),
            .gray    (gray),
            .clear   (pix_clear[p]),
            .pending (pending[p]),
            .le      (pix_le[p]),
            .te      (pix_te[p])
        );
    end

    // Lowest column wins, then lowest row: first hit in column-major order.
    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        sel_word   = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int r = 0; r < NROW; r++) begin
                if (!sel_found && pending[c*NROW + r]) begin
                    sel_found                = 1'b1;
                    sel_onehot[c*NROW + r]   = 1'b1;
                    sel_word.col             = 6'(c);
                    sel_word.row             = 9'(r);
                    sel_word.le              = pix_le[c*NROW + r];
                    sel_word.te              = pix_te[c*NROW + r];
                end
            end
        end
    end

    assign read_edge = pads.READ_PAD & ~read_q;
    assign pix_clear = sel_onehot & {NPIX{read_edge & ~conf_eff.en_test_pattern}};

    always_ff @(posedge CLK_BX_PAD or negedge RST_N_PAD) begin
        if (!RST_N_PAD) begin
            read_q     <= 1'b0;
            ser        <= '0;
            token_q    <= 1'b0;
            HIT_OR_PAD <= 1'b0;
        end else begin
            read_q     <= pads.READ_PAD;
            token_q    <= (|pending) & conf_eff.en_readout;
            HIT_OR_PAD <= |hit_eff;
            if (read_edge) begin
                if (conf_eff.en_test_pattern) begin
                    ser <= TEST_PATTERN;
                end else if (sel_found) begin
                    ser <= sel_word;
                end else begin
                    ser <= '0;
                end
            end else begin
                ser <= {ser[DATA_BITS-2:0], 1'b0};
            end
        end
    end

    assign pads.TOKEN_PAD = token_q;
    assign pads.OUT_PAD   = ser[DATA_BITS-1];

endmodule

// File: tb/tb_monopix.sv
// Directed scoreboard bench for monopix: stimulus pushes expected readout
// words, an independent monitor deserializes OUT_PAD after each READ edge.
module tb_monopix;
    import monopix_pkg::*;

    localparam int NCOL      = 4;
    localparam int NROW      = 8;
    localparam int NPIX      = NCOL * NROW;
    localparam int CONF_BITS = 2 + 2*NCOL + 2*NROW;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic            reset_bcid = 1'b0;
    logic            pulse      = 1'b0;
    logic [NPIX-1:0] ana_hit    = '0;
    logic            hit_or;

    monopix_if bus ();

    monopix #(.NCOL(NCOL), .NROW(NROW)) dut (
        .CLK_BX_PAD     (clk),
        .RST_N_PAD      (rst_n),
        .RESET_BCID_PAD (reset_bcid),
        .ANA_HIT        (ana_hit),
        .PULSE_PAD      (pulse),
        .HIT_OR_PAD     (hit_or),
        .pads           (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [26:0] exp_q [$];

    // Reference timestamp counter.
    logic [5:0] bcid_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bcid_m <= '0;
        else if (reset_bcid) bcid_m <= '0;
        else                 bcid_m <= bcid_m + 6'd1;
    end

    function automatic logic [5:0] gray6(input logic [5:0] b);
        return b ^ {1'b0, b[5:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: deserialize 27 bits starting with the cycle after a READ edge.
    logic        mon_read_q = 1'b0;
    logic        mon_re     = 1'b0;
    int          mon_cnt    = 0;
    logic [26:0] mon_word   = '0;
    always @(posedge clk) begin
        mon_re     = rst_n && bus.READ_PAD && !mon_read_q;
        mon_read_q = rst_n && bus.READ_PAD;
        #1;
        if (!rst_n) begin
            mon_cnt = 0;
        end else if (mon_re) begin
            mon_word = {26'd0, bus.OUT_PAD};
            mon_cnt  = 1;
        end else if (mon_cnt > 0) begin
            mon_word = {mon_word[25:0], bus.OUT_PAD};
            mon_cnt++;
        end
        if (mon_cnt == 27) begin
            mon_cnt = 0;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream_unexpected: got %0h expected none", mon_word);
            end else begin
                check("stream_word", {5'd0, mon_word}, {5'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_pulse();
        bus.READ_PAD = 1'b1;
        tick(1);
        bus.READ_PAD = 1'b0;
    endtask

    task automatic load_conf(input logic [CONF_BITS-1:0] v);
        for (int i = CONF_BITS-1; i >= 0; i--) begin
            bus.SI_CONF_PAD       = v[i];
            bus.CONF_SHIFT_EN_PAD = 1'b1;
            tick(1);
        end
        bus.CONF_SHIFT_EN_PAD = 1'b0;
        bus.SI_CONF_PAD       = 1'b0;
        bus.LD_CONF_PAD       = 1'b1;
        tick(1);
        bus.LD_CONF_PAD       = 1'b0;
    endtask

    // Drive a hit (ANA_HIT mask or injection pulse) for len clocks, return expected LE/TE.
    task automatic hit_pulse(input logic [NPIX-1:0] m, input logic use_pulse, input int len,
                             input logic exp_or, output logic [5:0] le, output logic [5:0] te);
        le = gray6(bcid_m);
        if (use_pulse) pulse = 1'b1;
        else           ana_hit = ana_hit | m;
        tick(1);
        check("hit_or", {31'd0, hit_or}, {31'd0, exp_or});
        tick(len - 1);
        te      = gray6(bcid_m);
        pulse   = 1'b0;
        ana_hit = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] le_a, te_a;
    logic       acc;
    localparam logic [CONF_BITS-1:0] V_INJ  = {1'b0, 1'b1, 4'hF, 8'hFF, 4'h4, 8'h04};
    localparam logic [CONF_BITS-1:0] V_MASK = {1'b0, 1'b1, 4'hD, 8'hFF, 4'h0, 8'h00};
    localparam logic [CONF_BITS-1:0] V_TP   = {1'b1, 1'b1, 4'hF, 8'hFF, 4'h0, 8'h00};

    initial begin
        bus.DEF_CONF_PAD      = 1'b1;
        bus.LD_CONF_PAD       = 1'b0;
        bus.SI_CONF_PAD       = 1'b0;
        bus.CONF_SHIFT_EN_PAD = 1'b0;
        bus.FREEZE_PAD        = 1'b0;
        bus.READ_PAD          = 1'b0;
        tick(2);
        check("rst_token",  {31'd0, bus.TOKEN_PAD},   32'd0);
        check("rst_out",    {31'd0, bus.OUT_PAD},     32'd0);
        check("rst_hit_or", {31'd0, hit_or},          32'd0);
        check("rst_so",     {31'd0, bus.SO_CONF_PAD}, 32'd0);
        rst_n = 1'b1;
        reset_bcid = 1'b1;
        tick(1);
        reset_bcid = 1'b0;
        tick(10);

        // Single hit on (0,0) starting at bcid 10 for 8 clocks
        hit_pulse(32'h1, 1'b0, 8, 1'b1, le_a, te_a);
        tick(1);
        check("token_latency", {31'd0, bus.TOKEN_PAD}, 32'd0);
        tick(1);
        check("token_set", {31'd0, bus.TOKEN_PAD}, 32'd1);
        exp_q.push_back({6'd0, gray6(6'd18), gray6(6'd10), 9'd0});
        read_pulse();
        tick(28);
        check("out_idle", {31'd0, bus.OUT_PAD}, 32'd0);
        check("token_clear", {31'd0, bus.TOKEN_PAD}, 32'd0);

        // (0,0) and (2,7) together: priority order
        hit_pulse(32'h1 | (32'h1 << 23), 1'b0, 3, 1'b1, le_a, te_a);
        tick(2);
        check("token_two", {31'd0, bus.TOKEN_PAD}, 32'd1);
        exp_q.push_back({6'd0, te_a, le_a, 9'd0});
        read_pulse();
        tick(30);
        check("token_one_left", {31'd0, bus.TOKEN_PAD}, 32'd1);
        exp_q.push_back({6'd2, te_a, le_a, 9'd7});
        read_pulse();
        tick(30);
        check("token_none_left", {31'd0, bus.TOKEN_PAD}, 32'd0);

        // Injection into (2,2) via shifted config
        load_conf(V_INJ);
        check("so_inj", {31'd0, bus.SO_CONF_PAD}, 32'd0);
        bus.DEF_CONF_PAD = 1'b0;
        hit_pulse('0, 1'b1, 4, 1'b1, le_a, te_a);
        tick(2);
        check("token_inj", {31'd0, bus.TOKEN_PAD}, 32'd1);
        exp_q.push_back({6'd2, te_a, le_a, 9'd2});
        read_pulse();
        tick(30);

        // Column 1 masked: hit on (1,3) invisible
        load_conf(V_MASK);
        hit_pulse(32'h1 << 11, 1'b0, 3, 1'b0, le_a, te_a);
        tick(3);
        check("token_masked", {31'd0, bus.TOKEN_PAD}, 32'd0);

        // Test pattern; pending (3,0) must survive the read
        load_conf(V_TP);
        check("so_tp", {31'd0, bus.SO_CONF_PAD}, 32'd1);
        hit_pulse(32'h1 << 24, 1'b0, 2, 1'b1, le_a, te_a);
        tick(2);
        check("token_tp", {31'd0, bus.TOKEN_PAD}, 32'd1);
        exp_q.push_back(27'h5555555);
        read_pulse();
        tick(30);
        check("token_tp_kept", {31'd0, bus.TOKEN_PAD}, 32'd1);
        check("out_tp_idle", {31'd0, bus.OUT_PAD}, 32'd0);

        // Reset in the middle of a test-pattern stream
        read_pulse();
        check("out_bit26", {31'd0, bus.OUT_PAD}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("out_async_rst", {31'd0, bus.OUT_PAD}, 32'd0);
        check("token_async_rst", {31'd0, bus.TOKEN_PAD}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        acc = 1'b0;
        repeat (5) begin
            tick(1);
            acc = acc | bus.OUT_PAD;
        end
        check("out_after_rst", {31'd0, acc}, 32'd0);
        check("token_after_rst", {31'd0, bus.TOKEN_PAD}, 32'd0);

        // Freeze swallows a complete pulse
        bus.FREEZE_PAD = 1'b1;
        hit_pulse(32'h1, 1'b0, 3, 1'b1, le_a, te_a);
        tick(2);
        bus.FREEZE_PAD = 1'b0;
        tick(3);
        check("token_frozen", {31'd0, bus.TOKEN_PAD}, 32'd0);

        // READ with nothing pending streams zeros
        exp_q.push_back(27'd0);
        read_pulse();
        tick(32);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
